// File: rtl/mult_rr_arbiter.sv
// Round-robin front end that shares one multi-cycle multiplier between
// G_NB_REQ requesters: grant, operand latch, start/done sequencing, timeout.
module mult_rr_arbiter #(
    parameter int G_NB_REQ     = 4,
    parameter int G_DATA_WIDTH = 8,
    parameter int G_TIMEOUT    = 64
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [G_NB_REQ-1:0]                req_valid,
    input  logic [G_NB_REQ*G_DATA_WIDTH-1:0]   req_a,
    input  logic [G_NB_REQ*G_DATA_WIDTH-1:0]   req_b,
    output logic [G_NB_REQ-1:0]                req_ready,
    output logic [G_NB_REQ-1:0]                rsp_valid,
    input  logic [G_NB_REQ-1:0]                rsp_ready,
    output logic [2*G_DATA_WIDTH-1:0]          rsp_result,
    output logic                               rsp_err,
    output logic                               mult_start,
    output logic [G_DATA_WIDTH-1:0]            mult_a,
    output logic [G_DATA_WIDTH-1:0]            mult_b,
    input  logic                               mult_done,
    input  logic [2*G_DATA_WIDTH-1:0]          mult_result,
    output logic                               busy
);

    localparam int N    = G_NB_REQ;
    localparam int W    = G_DATA_WIDTH;
    localparam int IDXW = $clog2(N);
    localparam int CNTW = $clog2(G_TIMEOUT);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(G_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // First requester found scanning ptr+1, ptr+2, ... modulo N.
    function automatic logic [IDXW-1:0] rr_pick(input logic [N-1:0] vld,
                                                input logic [IDXW-1:0] ptr);
        logic [IDXW-1:0] pick;
        logic [IDXW-1:0] idx_s;
        int              idx;
        pick = ptr;
        for (int k = N; k >= 1; k--) begin
            idx   = (int'(ptr) + k) % N;
            idx_s = IDXW'(idx);
            if (vld[idx_s]) begin
                pick = idx_s;
            end
        end
        return pick;
    endfunction

    state_t              state_r, state_nxt;
    logic [IDXW-1:0]     ptr_r, ptr_nxt;
    logic [IDXW-1:0]     owner_r, owner_nxt;
    logic [W-1:0]        mult_a_r, a_nxt;
    logic [W-1:0]        mult_b_r, b_nxt;
    logic [CNTW-1:0]     cnt_r, cnt_nxt, cnt_inc_s;
    logic [2*W-1:0]      res_r, res_nxt;
    logic                err_r, err_nxt;
    logic [N-1:0]        ready_s;
    logic [IDXW-1:0]     win_s;
    logic                busy_r, mult_start_r;
    logic [N-1:0]        rsp_valid_r, rsp_valid_nxt;

    assign win_s     = rr_pick(req_valid, ptr_r);
    assign cnt_inc_s = cnt_r + CNTW'(1);

    // Next-state and datapath next-values for the transaction sequencer.
    always_comb begin
        state_nxt     = state_r;
        ptr_nxt       = ptr_r;
        owner_nxt     = owner_r;
        a_nxt         = mult_a_r;
        b_nxt         = mult_b_r;
        cnt_nxt       = cnt_r;
        res_nxt       = res_r;
        err_nxt       = err_r;
        ready_s       = '0;
        rsp_valid_nxt = '0;
        case (state_r)
            ST_IDLE: begin
                if (|req_valid) begin
                    ready_s[win_s] = 1'b1;
                    owner_nxt      = win_s;
                    a_nxt          = req_a[int'(win_s)*W +: W];
                    b_nxt          = req_b[int'(win_s)*W +: W];
                    state_nxt      = ST_START;
                end else begin
                    state_nxt      = ST_IDLE;
                end
            end
            ST_START: begin
                cnt_nxt   = '0;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_nxt = cnt_inc_s;
                // A completion on the last allowed cycle still counts as success.
                if (mult_done) begin
                    res_nxt   = mult_result;
                    err_nxt   = 1'b0;
                    state_nxt = ST_RESP;
                end else if (cnt_inc_s == CNT_LAST) begin
                    res_nxt   = '0;
                    err_nxt   = 1'b1;
                    state_nxt = ST_RESP;
                end else begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready[owner_r]) begin
                    ptr_nxt   = owner_r;
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_RESP;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        if (state_nxt == ST_RESP) begin
            rsp_valid_nxt[owner_nxt] = 1'b1;
        end else begin
            rsp_valid_nxt = '0;
        end
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            ptr_r        <= IDXW'(N - 1);
            owner_r      <= '0;
            mult_a_r     <= '0;
            mult_b_r     <= '0;
            cnt_r        <= '0;
            res_r        <= '0;
            err_r        <= 1'b0;
            busy_r       <= 1'b0;
            mult_start_r <= 1'b0;
            rsp_valid_r  <= '0;
        end else begin
            state_r      <= state_nxt;
            ptr_r        <= ptr_nxt;
            owner_r      <= owner_nxt;
            mult_a_r     <= a_nxt;
            mult_b_r     <= b_nxt;
            cnt_r        <= cnt_nxt;
            res_r        <= res_nxt;
            err_r        <= err_nxt;
            busy_r       <= (state_nxt != ST_IDLE);
            mult_start_r <= (state_nxt == ST_START);
            rsp_valid_r  <= rsp_valid_nxt;
        end
    end

    assign req_ready  = ready_s;
    assign rsp_valid  = rsp_valid_r;
    assign rsp_result = res_r;
    assign rsp_err    = err_r;
    assign mult_start = mult_start_r;
    assign mult_a     = mult_a_r;
    assign mult_b     = mult_b_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_mult_rr_arbiter.sv
// Randomized bench for mult_rr_arbiter: clients, a multiplier stand-in and a
// transaction-level reference model, plus directed scenarios.
module tb_mult_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 64;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
    logic [N*W-1:0]   req_a, req_b;
    logic [2*W-1:0]   rsp_result, mult_result;
    logic             rsp_err, mult_start, mult_done, busy;
    logic [W-1:0]     mult_a, mult_b;

    mult_rr_arbiter #(.G_NB_REQ(N), .G_DATA_WIDTH(W), .G_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err), .mult_start(mult_start),
        .mult_a(mult_a), .mult_b(mult_b), .mult_done(mult_done),
        .mult_result(mult_result), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // clients
    bit pend [N];
    int pa [N];
    int pb [N];
    int p_req, p_rdy, p_drop, delay_mode;
    // reference model: phase 0 idle, 1 start, 2 wait, 3 respond
    int ph, ptr, own, ea, eb, waited, eres, eerr;
    // multiplier stand-in
    bit             m_armed;
    int             m_cnt, m_delay;
    logic [2*W-1:0] m_prod;
    // statistics
    int cyc, n_ready, n_start, start_cyc, resp_cyc, acc_cnt, last_res, last_err;
    bit prev_v;
    int glog [$];

    function automatic int pick(input logic [N-1:0] v, input int p);
        for (int k = 1; k <= N; k++) begin
            if (v[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic step(input bit do_rst);
        logic [N-1:0] er, ev;
        int           w;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(99) < p_req) begin
                pend[i] = 1'b1;
                pa[i]   = $urandom_range(255);
                pb[i]   = $urandom_range(255);
            end else if (pend[i] && $urandom_range(999) < p_drop) begin
                pend[i] = 1'b0;
            end
            req_valid[i]     = pend[i];
            req_a[i*W +: W]  = W'(pa[i]);
            req_b[i*W +: W]  = W'(pb[i]);
            rsp_ready[i]     = ($urandom_range(99) < p_rdy) ? 1'b1 : 1'b0;
        end
        mult_done   = 1'b0;
        mult_result = 16'($urandom);
        if (m_armed) begin
            m_cnt++;
            if (m_delay > 0 && m_cnt == m_delay) begin
                mult_done   = 1'b1;
                mult_result = m_prod;
                m_armed     = 1'b0;
            end
        end else if (ph == 1 && $urandom_range(3) == 0) begin
            mult_done = 1'b1;  // stray pulse while starting must be ignored
        end
        rst = do_rst;
        #1;
        w  = pick(req_valid, ptr);
        er = '0;
        if (ph == 0 && w >= 0) er[w] = 1'b1;
        ev = '0;
        if (ph == 3) ev[own] = 1'b1;
        check_val("busy", busy, (ph != 0));
        check_val("req_ready", req_ready, er);
        check_val("mult_start", mult_start, (ph == 1));
        check_val("rsp_valid", rsp_valid, ev);
        if (ph == 3) begin
            check_val("rsp_result", rsp_result, eres);
            check_val("rsp_err", rsp_err, eerr);
        end
        if (ph != 0) begin
            check_val("mult_a", mult_a, ea);
            check_val("mult_b", mult_b, eb);
        end
        if (req_ready != '0) n_ready++;
        if (mult_start === 1'b1) begin
            n_start++;
            start_cyc = cyc;
            m_armed   = 1'b1;
            m_cnt     = 0;
            m_prod    = mult_a * mult_b;
            if (delay_mode < 0)
                m_delay = ($urandom_range(9) == 0) ? $urandom_range(60, 70) : $urandom_range(1, 12);
            else
                m_delay = delay_mode;
        end
        if (rsp_valid != '0 && !prev_v) resp_cyc = cyc;
        prev_v = (rsp_valid != '0);
        // model advance across the coming edge
        if (do_rst) begin
            ph      = 0;
            ptr     = N - 1;
            m_armed = 1'b0;
        end else begin
            case (ph)
                0: if (w >= 0) begin
                    own = w; ea = pa[w]; eb = pb[w];
                    pend[w] = 1'b0;
                    glog.push_back(w);
                    ph = 1;
                end
                1: begin ph = 2; waited = 0; end
                2: begin
                    waited++;
                    if (mult_done) begin
                        eres = ea * eb; eerr = 0; ph = 3;
                    end else if (waited == TO - 1) begin
                        eres = 0; eerr = 1; ph = 3;
                    end
                end
                3: if (rsp_ready[own]) begin
                    last_res = rsp_result;
                    last_err = rsp_err;
                    acc_cnt++;
                    ptr = own;
                    ph  = 0;
                end
                default: ph = 0;
            endcase
        end
        cyc++;
    endtask

    task automatic run_txn(input string tag, input int max);
        int c0 = acc_cnt;
        int n  = 0;
        while (acc_cnt == c0 && n < max) begin
            step(1'b0);
            n++;
        end
        check_val({tag, "_completed"}, (acc_cnt != c0), 1);
    endtask

    task automatic drain();
        int n = 0;
        p_req = 0;
        p_rdy = 100;
        for (int i = 0; i < N; i++) pend[i] = 1'b0;
        while (ph != 0 && n < 200) begin
            step(1'b0);
            n++;
        end
        check_val("drain_idle", (ph == 0), 1);
    endtask

    initial begin
        int s0, r0;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = '0;
        mult_done = 1'b0; mult_result = '0;
        for (int i = 0; i < N; i++) begin pend[i] = 1'b0; pa[i] = 0; pb[i] = 0; end
        p_req = 0; p_rdy = 100; p_drop = 0; delay_mode = 5;
        ph = 0; ptr = N - 1; own = 0; ea = 0; eb = 0; waited = 0; eres = 0; eerr = 0;
        m_armed = 1'b0; m_cnt = 0; m_delay = 0; m_prod = '0;
        cyc = 0; n_ready = 0; n_start = 0; start_cyc = 0; resp_cyc = 0;
        acc_cnt = 0; last_res = 0; last_err = 0; prev_v = 1'b0;

        step(1'b1);
        step(1'b1);
        check_val("rst_mult_a", mult_a, 0);
        check_val("rst_mult_b", mult_b, 0);
        check_val("rst_result", rsp_result, 0);
        check_val("rst_err", rsp_err, 0);

        // single request, done five cycles after start
        s0 = n_start; r0 = n_ready;
        pend[0] = 1'b1; pa[0] = 12; pb[0] = 13;
        run_txn("single", 40);
        check_val("single_result", last_res, 156);
        check_val("single_err", last_err, 0);
        check_val("single_starts", n_start - s0, 1);
        check_val("single_ready_cycles", n_ready - r0, 1);

        // round robin from reset with everyone requesting
        step(1'b1);
        glog.delete();
        p_req = 100; delay_mode = 3;
        for (int n = 0; n < 200 && glog.size() < 8; n++) step(1'b0);
        check_val("rr_count", (glog.size() >= 8), 1);
        for (int k = 0; k < 8 && k < glog.size(); k++) check_val("rr_order", glog[k], k % N);
        drain();

        // timeout then normal service
        delay_mode = 0;
        pend[2] = 1'b1; pa[2] = 7; pb[2] = 9;
        run_txn("timeout", 120);
        check_val("timeout_err", last_err, 1);
        check_val("timeout_result", last_res, 0);
        check_val("timeout_latency", resp_cyc - start_cyc, 64);
        delay_mode = 4;
        pend[1] = 1'b1; pa[1] = 200; pb[1] = 3;
        run_txn("after_timeout", 40);
        check_val("after_timeout_result", last_res, 600);
        check_val("after_timeout_err", last_err, 0);

        // response backpressure with other requests pending
        p_rdy = 0; delay_mode = 2;
        pend[0] = 1'b1; pa[0] = 5; pb[0] = 6;
        pend[1] = 1'b1; pa[1] = 8; pb[1] = 9;
        pend[3] = 1'b1; pa[3] = 10; pb[3] = 11;
        for (int n = 0; n < 40 && ph != 3; n++) step(1'b0);
        check_val("bp_in_resp", ph, 3);
        s0 = n_start; r0 = n_ready;
        for (int n = 0; n < 10; n++) step(1'b0);
        check_val("bp_no_start", n_start - s0, 0);
        check_val("bp_no_ready", n_ready - r0, 0);
        drain();

        // reset while waiting on the multiplier
        delay_mode = 0;
        pend[2] = 1'b1; pa[2] = 33; pb[2] = 44;
        for (int n = 0; n < 40 && !(ph == 2 && waited >= 3); n++) step(1'b0);
        check_val("mid_wait_reached", (ph == 2), 1);
        for (int i = 0; i < N; i++) begin pend[i] = 1'b1; pa[i] = i + 1; pb[i] = i + 2; end
        glog.delete();
        step(1'b1);
        step(1'b0);
        check_val("post_rst_busy", busy, 0);
        check_val("post_rst_rsp_valid", rsp_valid, 0);
        check_val("post_rst_first_grant", (glog.size() > 0) ? glog[0] : -1, 0);
        delay_mode = 2;
        drain();

        // edge operands and done on the timeout cycle
        delay_mode = 3;
        pend[3] = 1'b1; pa[3] = 255; pb[3] = 255;
        run_txn("max_operands", 40);
        check_val("max_result", last_res, 65025);
        delay_mode = TO - 1;
        pend[0] = 1'b1; pa[0] = 17; pb[0] = 19;
        run_txn("done_at_timeout", 120);
        check_val("done_at_timeout_err", last_err, 0);
        check_val("done_at_timeout_result", last_res, 323);

        // random traffic with occasional resets and abandoned requests
        p_req = 30; p_rdy = 60; p_drop = 20; delay_mode = -1;
        for (int n = 0; n < 4000; n++) step($urandom_range(399) == 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
